memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares the single RAM port among the instruction and data cache requesters of every CPU. It sits between the per-CPU cache blocks and the RAM, on the memory side of `cache_control_if`. It grants one request at a time, holds that grant until the RAM completes, and returns wait/load to the granted requester only. Priority is data over instruction, with round-robin between CPUs.

## Interface
Parameters:
- CPUS, 2, number of CPUs; requesters are one icache and one dcache per CPU.

Ports (CPUS-wide vectors index by CPU ID):
- CLK  in  1  system clock; all state changes on rising edge.
- nRST  in  1  synchronous, active-low reset.
- iREN  in  CPUS  instruction read request per CPU.
- iaddr  in  CPUS x 32  instruction word address.
- iwait  out  CPUS  1 = instruction request not complete.
- iload  out  CPUS x 32  instruction read data.
- dREN  in  CPUS  data read request.
- dWEN  in  CPUS  data write request.
- daddr  in  CPUS x 32  data address.
- dstore  in  CPUS x 32  data write value.
- dwait  out  CPUS  1 = data request not complete.
- dload  out  CPUS x 32  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- err  out  1  sticky flag, set when any transaction completes with ERROR.

## Operation
FSM states:
- IDLE: no grant; RAM enables low.
  - If any request is pending, register the grant and go to BUSY.
- BUSY: drive the RAM from the granted requester.
  - ACCESS: complete and go to DONE.
  - ERROR: set err, complete and go to DONE.
  - Granted request dropped (abort): go to IDLE without completion.
- DONE: one-cycle turnaround; enables low; advance the round-robin pointer; go to IDLE.

Arbitration, evaluated in IDLE only:
- Candidate order starts at CPU rr_ptr and wraps modulo CPUS.
- Any pending data request, from any CPU, beats any instruction request.
- Within the data class or within the instruction class, the first CPU in the candidate order wins.
- dWEN and dREN together from one CPU: treat as a write (ramWEN=1, ramREN=0).

Grant register: {cpu index, is_data, is_write}, held for the whole of BUSY.
- Address and store data pass through combinationally from the granted requester's live inputs.

Round-robin pointer:
- rr_ptr advances to (granted cpu + 1) mod CPUS in DONE.
- It is unchanged on abort.

Completion (the BUSY cycle with ramstate ACCESS or ERROR):
- The granted requester's wait is 0 for exactly that cycle.
- Its load equals ramload; it is driven for data reads and for instruction reads.
- For writes, dload = ramload (don't-care for the requester).

Wait signals:
- All non-granted waits stay 1.
- A requester whose REN/WEN is low still reports wait=1; caches qualify wait with their own request.

Load outputs:
- Outside completion, each load output holds its last completed value (registered per requester).
- Reset value of each load output is 0.

Reset (nRST low at an edge):
- State returns to IDLE, grant and rr_ptr clear to 0, err clears.
- Every wait output becomes 1; ramREN/ramWEN become 0; ramaddr/ramstore become 0; all loads become 0.
- Reset mid-BUSY aborts the transaction without completion.

## Timing
- Request seen in IDLE at edge N → BUSY from N; RAM enables are high in cycle N+1.
- Earliest completion: the cycle in which ramstate=ACCESS during BUSY, so minimum one cycle after grant.
- Back-to-back throughput: one transaction per (RAM latency + 2) cycles, counting the IDLE and DONE cycles.
- ramREN and ramWEN are never both 1, and are never 1 outside BUSY.
- A request that arrives while another is in BUSY waits for IDLE; it is not preempted, even if it has higher class priority.

## Test plan
- Single read: CPU0 iREN, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with 0xDEADBEEF → iwait[0]=0 for one cycle, iload[0]=0xDEADBEEF; ramREN high for 2 cycles.
- Class priority: CPU0 iREN and CPU1 dREN asserted together in IDLE → CPU1 data served first, CPU0 instruction next; iwait[0] stays 1 through the first transaction.
- Round-robin: both CPUs hold dWEN continuously, 4 transactions → grant order 0,1,0,1; ramstore matches each CPU's dstore.
- Write+read conflict: CPU0 dREN=dWEN=1, daddr=0x80, dstore=0x12345678 → ramWEN=1, ramREN=0, ramaddr=0x80.
- Error and abort:
  - ramstate=ERROR during BUSY → one-cycle wait drop and err=1 sticky.
  - Requester drops its request mid-BUSY → return to IDLE, no wait drop, rr_ptr unchanged.
- Reset mid-transaction: nRST low during BUSY → next cycle all waits 1, RAM enables 0, err 0, loads 0; a request after reset is granted CPU0-first.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port among per-CPU icache/dcache requesters.
// Data beats instruction; round-robin between CPUs; one grant held to completion.
module memory_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CPUS-1:0]     iREN,
  input  logic [32*CPUS-1:0]  iaddr,
  output logic [CPUS-1:0]     iwait,
  output logic [32*CPUS-1:0]  iload,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  logic [32*CPUS-1:0]  daddr,
  input  logic [32*CPUS-1:0]  dstore,
  output logic [CPUS-1:0]     dwait,
  output logic [32*CPUS-1:0]  dload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [31:0]         ramaddr,
  output logic [31:0]         ramstore,
  input  logic [31:0]         ramload,
  input  logic [1:0]          ramstate,
  output logic                err
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;

  logic [CW-1:0] gnt_cpu;
  logic          gnt_data;
  logic          gnt_write;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] rr_next;

  logic          d_hit;
  logic          i_hit;
  logic [CW-1:0] d_sel;
  logic [CW-1:0] i_sel;
  logic [CW-1:0] idx;
  logic [CW-1:0] sel_cpu;
  logic          sel_data;
  logic          sel_write;
  logic          any_req;

  logic          busy;
  logic          req_live;
  logic          cmpl;
  logic          abort;
  logic          hit_i;
  logic          hit_d;

  logic [31:0]   ia [CPUS];
  logic [31:0]   da [CPUS];
  logic [31:0]   ds [CPUS];
  logic [31:0]   iload_q [CPUS];
  logic [31:0]   dload_q [CPUS];

  // Split the flat per-CPU buses into word arrays.
  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      ia[c] = iaddr[c*32 +: 32];
      da[c] = daddr[c*32 +: 32];
      ds[c] = dstore[c*32 +: 32];
    end
  end

  // Scan CPUs from rr_ptr; first pending data and instruction requester.
  always_comb begin
    d_hit = 1'b0;
    i_hit = 1'b0;
    d_sel = '0;
    i_sel = '0;
    idx   = '0;
    for (int k = 0; k < CPUS; k++) begin
      idx = CW'((int'(rr_ptr) + k) % CPUS);
      if (!d_hit && (dREN[idx] || dWEN[idx])) begin
        d_hit = 1'b1;
        d_sel = idx;
      end
      if (!i_hit && iREN[idx]) begin
        i_hit = 1'b1;
        i_sel = idx;
      end
    end
  end

  assign any_req   = d_hit | i_hit;
  assign sel_cpu   = d_hit ? d_sel : i_sel;
  assign sel_data  = d_hit;
  assign sel_write = d_hit & dWEN[d_sel];
  assign rr_next   = CW'((int'(gnt_cpu) + 1) % CPUS);

  assign busy     = (state == BUSY);
  assign req_live = gnt_data ? (dREN[gnt_cpu] | dWEN[gnt_cpu])
                             : iREN[gnt_cpu];
  assign abort    = busy & ~req_live;
  assign cmpl     = busy & req_live &
                    ((ramstate == 2'd2) | (ramstate == 2'd3));

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; a dropped request abandons the grant.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any_req) state_n = BUSY;
      BUSY: begin
        if (abort)     state_n = IDLE;
        else if (cmpl) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // RAM drive from the granted requester; waits and loads per requester.
  always_comb begin
    ramREN   = busy & ~gnt_write;
    ramWEN   = busy & gnt_write;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    hit_i    = 1'b0;
    hit_d    = 1'b0;
    if (busy) begin
      ramaddr  = gnt_data ? da[gnt_cpu] : ia[gnt_cpu];
      ramstore = gnt_data ? ds[gnt_cpu] : 32'd0;
    end
    for (int c = 0; c < CPUS; c++) begin
      hit_i = cmpl & ~gnt_data & (gnt_cpu == CW'(c));
      hit_d = cmpl & gnt_data & (gnt_cpu == CW'(c));
      iwait[c] = ~hit_i;
      dwait[c] = ~hit_d;
      iload[c*32 +: 32] = hit_i ? ramload : iload_q[c];
      dload[c*32 +: 32] = hit_d ? ramload : dload_q[c];
    end
  end

  // Grant capture, round-robin pointer, sticky error and load holding.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      gnt_cpu   <= '0;
      gnt_data  <= 1'b0;
      gnt_write <= 1'b0;
      rr_ptr    <= '0;
      err       <= 1'b0;
      for (int c = 0; c < CPUS; c++) begin
        iload_q[c] <= '0;
        dload_q[c] <= '0;
      end
    end else begin
      if (state == IDLE && any_req) begin
        gnt_cpu   <= sel_cpu;
        gnt_data  <= sel_data;
        gnt_write <= sel_write;
      end
      if (state == DONE) rr_ptr <= rr_next;
      if (cmpl && ramstate == 2'd3) err <= 1'b1;
      if (cmpl) begin
        if (gnt_data) dload_q[gnt_cpu] <= ramload;
        else          iload_q[gnt_cpu] <= ramload;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios for memory_arbiter with CPUS=2.
// Each task drives a scenario and checks outputs 3ns after the rising edge.
module tb_memory_arbiter;

  logic        CLK;
  logic        nRST;
  logic [1:0]  iREN;
  logic [63:0] iaddr;
  logic [1:0]  iwait;
  logic [63:0] iload;
  logic [1:0]  dREN;
  logic [1:0]  dWEN;
  logic [63:0] daddr;
  logic [63:0] dstore;
  logic [1:0]  dwait;
  logic [63:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  int checks;
  int failures;

  memory_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    iREN = '0;
    dREN = '0;
    dWEN = '0;
    ramstate = 2'd0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_req();
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    step(); step();
    #2;
    checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL rst_iwait got=%b exp=11", iwait); end
    checks++; if (dwait !== 2'b11) begin failures++; $display("FAIL rst_dwait got=%b exp=11", dwait); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("FAIL rst_en got=%b exp=00", {ramREN, ramWEN}); end
    checks++; if (ramaddr !== 32'd0) begin failures++; $display("FAIL rst_addr got=%h exp=0", ramaddr); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if ({iload, dload} !== 128'd0) begin failures++; $display("FAIL rst_load got=%h exp=0", {iload, dload}); end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    iREN = 2'b01; iaddr[31:0] = 32'h40;
    #2;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL sr_idle_ren got=%b exp=0", ramREN); end
    step(); ramstate = 2'd1;
    #2;
    checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL sr_ren1 got=%b exp=1", ramREN); end
    checks++; if (ramaddr !== 32'h40) begin failures++; $display("FAIL sr_addr got=%h exp=40", ramaddr); end
    checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL sr_wait_busy got=%b exp=11", iwait); end
    step(); ramstate = 2'd2; ramload = 32'hDEADBEEF;
    #2;
    checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL sr_ren2 got=%b exp=1", ramREN); end
    checks++; if (iwait !== 2'b10) begin failures++; $display("FAIL sr_wait_done got=%b exp=10", iwait); end
    checks++; if (iload[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL sr_load got=%h exp=deadbeef", iload[31:0]); end
    step(); clear_req(); ramload = 32'h0;
    #2;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL sr_done_ren got=%b exp=0", ramREN); end
    checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL sr_wait_after got=%b exp=11", iwait); end
    checks++; if (iload[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL sr_load_hold got=%h exp=deadbeef", iload[31:0]); end
    step();
  endtask

  task automatic test_class_priority();
    iREN = 2'b01; iaddr[31:0] = 32'h44;
    dREN = 2'b10; daddr[63:32] = 32'h100;
    step(); ramstate = 2'd2; ramload = 32'hAAAA0001;
    #2;
    checks++; if (dwait !== 2'b01) begin failures++; $display("FAIL cp_dwait got=%b exp=01", dwait); end
    checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL cp_iwait got=%b exp=11", iwait); end
    checks++; if (ramaddr !== 32'h100) begin failures++; $display("FAIL cp_addr1 got=%h exp=100", ramaddr); end
    checks++; if (dload[63:32] !== 32'hAAAA0001) begin failures++; $display("FAIL cp_dload got=%h exp=aaaa0001", dload[63:32]); end
    step(); dREN = 2'b00; ramstate = 2'd0;
    #2;
    checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL cp_iwait_done got=%b exp=11", iwait); end
    step();
    step(); ramstate = 2'd2; ramload = 32'h00000011;
    #2;
    checks++; if (ramaddr !== 32'h44) begin failures++; $display("FAIL cp_addr2 got=%h exp=44", ramaddr); end
    checks++; if (iwait !== 2'b10) begin failures++; $display("FAIL cp_iwait2 got=%b exp=10", iwait); end
    step(); clear_req();
    step();
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_st;
    int          cpu;
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    dWEN = 2'b11;
    daddr = {32'h14, 32'h10};
    dstore = {32'hB1B1B1B1, 32'hA0A0A0A0};
    for (int t = 0; t < 4; t++) begin
      cpu = t % 2;
      exp_st = (cpu == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
      step(); ramstate = 2'd2;
      #2;
      checks++; if ({ramWEN, ramREN} !== 2'b10) begin failures++; $display("FAIL rr_en t=%0d got=%b exp=10", t, {ramWEN, ramREN}); end
      checks++; if (ramstore !== exp_st) begin failures++; $display("FAIL rr_store t=%0d got=%h exp=%h", t, ramstore, exp_st); end
      checks++; if (dwait !== ((cpu == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_dwait t=%0d got=%b exp_cpu=%0d", t, dwait, cpu); end
      step(); ramstate = 2'd0;
      #2;
      checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL rr_done_wen t=%0d got=%b exp=0", t, ramWEN); end
      step();
    end
    clear_req();
    step();
  endtask

  task automatic test_write_read_conflict();
    dREN = 2'b01; dWEN = 2'b01;
    daddr[31:0] = 32'h80; dstore[31:0] = 32'h12345678;
    step(); ramstate = 2'd1;
    #2;
    checks++; if ({ramWEN, ramREN} !== 2'b10) begin failures++; $display("FAIL wr_en got=%b exp=10", {ramWEN, ramREN}); end
    checks++; if (ramaddr !== 32'h80) begin failures++; $display("FAIL wr_addr got=%h exp=80", ramaddr); end
    checks++; if (ramstore !== 32'h12345678) begin failures++; $display("FAIL wr_store got=%h exp=12345678", ramstore); end
    step(); ramstate = 2'd2;
    #2;
    checks++; if (dwait !== 2'b10) begin failures++; $display("FAIL wr_dwait got=%b exp=10", dwait); end
    step(); clear_req();
    step();
  endtask

  task automatic test_error();
    dREN = 2'b10; daddr[63:32] = 32'h200;
    step(); ramstate = 2'd3; ramload = 32'h00000BAD;
    #2;
    checks++; if (dwait !== 2'b01) begin failures++; $display("FAIL er_dwait got=%b exp=01", dwait); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL er_err_early got=%b exp=0", err); end
    step(); clear_req();
    #2;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL er_err_set got=%b exp=1", err); end
    checks++; if (dwait !== 2'b11) begin failures++; $display("FAIL er_dwait_done got=%b exp=11", dwait); end
    step();
    #2;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL er_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_abort();
    iREN = 2'b10; iaddr[63:32] = 32'h300;
    step(); ramstate = 2'd1;
    #2;
    checks++; if (ramaddr !== 32'h300) begin failures++; $display("FAIL ab_addr got=%h exp=300", ramaddr); end
    iREN = 2'b00;
    #1;
    checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL ab_wait_drop got=%b exp=11", iwait); end
    step(); ramstate = 2'd0;
    #2;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL ab_idle_ren got=%b exp=0", ramREN); end
    checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL ab_wait_idle got=%b exp=11", iwait); end
    iREN = 2'b11; iaddr[31:0] = 32'h48;
    step(); ramstate = 2'd2; ramload = 32'h55;
    #2;
    checks++; if (iwait !== 2'b10) begin failures++; $display("FAIL ab_rr_kept got=%b exp=10", iwait); end
    step(); clear_req();
    step();
  endtask

  task automatic test_reset_mid();
    dREN = 2'b10; daddr[63:32] = 32'h400;
    step(); ramstate = 2'd1;
    #2;
    checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL rm_busy got=%b exp=1", ramREN); end
    nRST = 1'b0;
    step();
    #2;
    checks++; if ({iwait, dwait} !== 4'b1111) begin failures++; $display("FAIL rm_waits got=%b exp=1111", {iwait, dwait}); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("FAIL rm_en got=%b exp=00", {ramREN, ramWEN}); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rm_err got=%b exp=0", err); end
    checks++; if ({iload, dload} !== 128'd0) begin failures++; $display("FAIL rm_loads got=%h exp=0", {iload, dload}); end
    nRST = 1'b1; dREN = 2'b11; ramstate = 2'd0;
    step(); ramstate = 2'd2;
    #2;
    checks++; if (dwait !== 2'b10) begin failures++; $display("FAIL rm_cpu0_first got=%b exp=10", dwait); end
    step(); clear_req();
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_read();
    test_class_priority();
    test_round_robin();
    test_write_read_conflict();
    test_error();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
